fp8_alu_arbiter: RTL and testbench

- Shares one combinational fp8_alu among NUM_REQ independent requesters using round-robin arbitration.
- Each requester presents operands and an opcode with a valid/ready handshake.
- The block registers the chosen operation, runs it through the ALU, and returns the result, exception flags and requester ID on a single response channel with backpressure.
- Sits between the FP8 compute clients and the fp8_alu datapath.

---
 rtl/fp8_pkg.sv | 71 +++++++
 rtl/fp8_alu.sv | 131 +++++++++++++
 rtl/fp8_alu_arbiter_rr_arbiter.sv | 49 ++++
 rtl/fp8_alu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fp8_alu_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp8_pkg.sv
// ============================================================================
// Module      : fp8_pkg
// Description : Shared definitions for the FP8 ALU arbiter slice.
//               - opcodes OP_ADD..OP_NOT
//               - FP8 field widths and exponent bias
//               - flag bit indices
//               - arbiter state enum
//               - packing helper that range-checks a normalised result
//               FP8 format: {sign, exp[2:0] (bias 3), frac[3:0]}.
//               An exponent field of zero encodes zero; there are no
//               inf/NaN codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp8_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam int EXP_W    = 3;
    localparam int FRAC_W   = 4;
    localparam int EXP_BIAS = 3;
    localparam int EXP_MAX  = (1 << EXP_W) - 1;

    localparam int FLG_INV = 3;
    localparam int FLG_OV  = 2;
    localparam int FLG_UF  = 1;
    localparam int FLG_Z   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic       ov;
        logic       uf;
        logic [7:0] val;
    } fp8_pack_t;

    // Packs a normalised (sign, unbiased-range exponent field, fraction).
    // Exponent fields above the top code saturate to the largest
    // magnitude; fields below 1 flush to signed zero.
    function automatic fp8_pack_t fp8_pack(input logic       sign,
                                           input int         exp_fld,
                                           input logic [3:0] frac);
        fp8_pack_t r;
        r = '{ov: 1'b0, uf: 1'b0, val: 8'h00};
        if (exp_fld > EXP_MAX) begin
            r.ov  = 1'b1;
            r.val = {sign, 7'h7F};
        end else if (exp_fld < 1) begin
            r.uf  = 1'b1;
            r.val = {sign, 7'h00};
        end else begin
            r.val = {sign, exp_fld[2:0], frac};
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp8_alu.sv
// ============================================================================
// Module      : fp8_alu
// Description : Combinational FP8 arithmetic / logic unit.
//               Arithmetic results are truncated (round toward zero).
// Ports       : a_i, b_i   - FP8 operands
//               op_i       - opcode (see fp8_pkg)
//               result_o   - 8-bit result
//               flags_o    - {invalid_op, overflow, underflow, zero}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp8_alu
    import fp8_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [2:0] op_i,
    output logic [7:0] result_o,
    output logic [3:0] flags_o
);

    logic       sign_a, sign_b, sign_b_eff, sign_p;
    logic [2:0] exp_a, exp_b;
    logic [4:0] man_a, man_b;
    logic       zero_a, zero_b;

    assign sign_a     = a_i[7];
    assign sign_b     = b_i[7];
    assign exp_a      = a_i[6:4];
    assign exp_b      = b_i[6:4];
    assign man_a      = {1'b1, a_i[3:0]};
    assign man_b      = {1'b1, b_i[3:0]};
    assign zero_a     = (exp_a == 3'd0);
    assign zero_b     = (exp_b == 3'd0);
    assign sign_b_eff = sign_b ^ (op_i == OP_SUB);
    assign sign_p     = sign_a ^ sign_b;

    // Add/sub: order by magnitude so the difference is never negative,
    // and keep three guard bits so subtraction borrows land correctly.
    logic       a_ge_b, same_sign, sign_l;
    logic [2:0] exp_l, exp_s;
    logic [7:0] ext_l, ext_s, diff, norm;
    logic [8:0] sum;
    int         msb;

    assign a_ge_b    = (a_i[6:0] >= b_i[6:0]);
    assign same_sign = (sign_a == sign_b_eff);
    assign sign_l    = a_ge_b ? sign_a : sign_b_eff;
    assign exp_l     = a_ge_b ? exp_a : exp_b;
    assign exp_s     = a_ge_b ? exp_b : exp_a;
    assign ext_l     = {(a_ge_b ? man_a : man_b), 3'b000};
    assign ext_s     = {(a_ge_b ? man_b : man_a), 3'b000} >> (exp_l - exp_s);
    assign sum       = {1'b0, ext_l} + {1'b0, ext_s};
    assign diff      = ext_l - ext_s;

    always_comb begin
        msb = 0;
        for (int i = 0; i < 8; i++) begin
            if (diff[i]) msb = i;
        end
    end

    assign norm = diff << (7 - msb);

    // Mul/div on 5-bit significands (implicit one restored).
    logic [9:0] prod;
    logic [5:0] quot;

    assign prod = {5'b00000, man_a} * {5'b00000, man_b};
    assign quot = 6'({man_a, 5'b00000} / {5'b00000, man_b});

    fp8_pack_t pk;
    logic      inv;
    logic      is_arith;

    always_comb begin
        pk       = '{ov: 1'b0, uf: 1'b0, val: 8'h00};
        inv      = 1'b0;
        is_arith = 1'b1;
        case (op_i)
            OP_ADD, OP_SUB: begin
                if (zero_a && zero_b)      pk.val = 8'h00;
                else if (zero_a)           pk.val = {sign_b_eff, b_i[6:0]};
                else if (zero_b)           pk.val = a_i;
                else if (same_sign) begin
                    if (sum[8]) pk = fp8_pack(sign_l, int'(exp_l) + 1, sum[7:4]);
                    else        pk = fp8_pack(sign_l, int'(exp_l), sum[6:3]);
                end
                else if (diff == 8'h00)    pk.val = 8'h00;
                else pk = fp8_pack(sign_l, int'(exp_l) - (7 - msb), norm[6:3]);
            end
            OP_MUL: begin
                if (zero_a || zero_b) pk.val = {sign_p, 7'h00};
                else if (prod[9])
                    pk = fp8_pack(sign_p, int'(exp_a) + int'(exp_b) - EXP_BIAS + 1, prod[8:5]);
                else
                    pk = fp8_pack(sign_p, int'(exp_a) + int'(exp_b) - EXP_BIAS, prod[7:4]);
            end
            OP_DIV: begin
                if (zero_b) begin
                    inv    = 1'b1;
                    pk.val = {sign_p, 7'h7F};
                end
                else if (zero_a) pk.val = {sign_p, 7'h00};
                else if (quot[5])
                    pk = fp8_pack(sign_p, int'(exp_a) - int'(exp_b) + EXP_BIAS, quot[4:1]);
                else
                    pk = fp8_pack(sign_p, int'(exp_a) - int'(exp_b) + EXP_BIAS - 1, quot[3:0]);
            end
            OP_AND: begin is_arith = 1'b0; pk.val = a_i & b_i; end
            OP_OR:  begin is_arith = 1'b0; pk.val = a_i | b_i; end
            OP_XOR: begin is_arith = 1'b0; pk.val = a_i ^ b_i; end
            default: begin is_arith = 1'b0; pk.val = ~a_i; end
        endcase
    end

    assign result_o         = pk.val;
    assign flags_o[FLG_INV] = inv;
    assign flags_o[FLG_OV]  = pk.ov;
    assign flags_o[FLG_UF]  = pk.uf;
    // Arithmetic zero ignores the sign bit; logical zero needs all bits clear.
    assign flags_o[FLG_Z]   = is_arith ? (pk.val[6:0] == 7'h00) : (pk.val == 8'h00);

    // Truncated guard bits and the redundant leading one are dropped.
    logic unused_bits;
    assign unused_bits = ^{sum[2:0], norm[7], norm[2:0], prod[3:0]};

endmodule

`default_nettype wire

// File: rtl/fp8_alu_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The search starts one
//               past the last grant and wraps; the first active request wins.
// Ports       : req_i        - request vector
//               last_grant_i - index granted most recently
//               grant_o      - one-hot grant (zero when no request)
//               grant_idx_o  - encoded winner index
//               grant_vld_o  - at least one request was seen
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               grant_vld_o
);

    int              cand;
    logic [ID_W-1:0] cidx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        cand        = 0;
        cidx        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_vld_o) begin
                cand = (int'(last_grant_i) + k) % NUM_REQ;
                cidx = ID_W'(cand);
                if (req_i[cidx]) begin
                    grant_vld_o   = 1'b1;
                    grant_o[cidx] = 1'b1;
                    grant_idx_o   = cidx;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp8_alu_arbiter.sv
// ============================================================================
// Module      : fp8_alu_arbiter
// Description : Shares one fp8_alu among NUM_REQ requesters using
//               round-robin arbitration. Each operation runs through
//               IDLE -> EXEC -> RESP.
//               Optional feature macro FP8_ARB_STICKY_FLAGS_EN adds
//               sticky_clr / sticky_flags accumulation.
// Ports       : clk, rst_n           - clock, async active-low reset
//               req_valid/req_ready  - per-requester handshake
//               req_a/req_b/req_op   - packed per-requester operands
//               rsp_*                - response channel with backpressure
//               busy                 - high whenever not IDLE
//               sticky_clr, sticky_flags (feature macro only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp8_alu_arbiter
    import fp8_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [3*NUM_REQ-1:0] req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_result,
    output logic [3:0]           rsp_flags,
    output logic                 busy
`ifdef FP8_ARB_STICKY_FLAGS_EN
    ,
    input  logic                 sticky_clr,
    output logic [3:0]           sticky_flags
`endif
);

    // Unpack per-requester operand slices.
    logic [7:0] a_arr  [NUM_REQ];
    logic [7:0] b_arr  [NUM_REQ];
    logic [2:0] op_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g]  = req_a[8*g +: 8];
        assign b_arr[g]  = req_b[8*g +: 8];
        assign op_arr[g] = req_op[3*g +: 3];
    end

    arb_state_e      state_q;
    logic [ID_W-1:0] last_grant_q;
    logic [7:0]      iss_a_q, iss_b_q;
    logic [2:0]      iss_op_q;
    logic [ID_W-1:0] iss_id_q;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [7:0]      rsp_result_q;
    logic [3:0]      rsp_flags_q;
    logic            busy_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;
    logic [7:0]         alu_result;
    logic [3:0]         alu_flags;
    logic               rsp_hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .grant_vld_o  (grant_vld)
    );

    fp8_alu u_fp8_alu (
        .a_i      (iss_a_q),
        .b_i      (iss_b_q),
        .op_i     (iss_op_q),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    // Gated by rst_n so no accept is signalled while reset is held.
    assign req_ready = (rst_n && (state_q == ST_IDLE)) ? grant : '0;
    assign rsp_hs    = rsp_valid_q & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            iss_a_q      <= 8'h00;
            iss_b_q      <= 8'h00;
            iss_op_q     <= 3'b000;
            iss_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= 8'h00;
            rsp_flags_q  <= 4'h0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        iss_a_q  <= a_arr[grant_idx];
                        iss_b_q  <= b_arr[grant_idx];
                        iss_op_q <= op_arr[grant_idx];
                        iss_id_q <= grant_idx;
                        busy_q   <= 1'b1;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_flags_q  <= alu_flags;
                    rsp_id_q     <= iss_id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        last_grant_q <= rsp_id_q;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = busy_q;

`ifdef FP8_ARB_STICKY_FLAGS_EN
    logic [3:0] sticky_q;

    // A clear coinciding with a handshake keeps only the new flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 4'h0;
        end else if (rsp_hs) begin
            sticky_q <= sticky_clr ? rsp_flags_q : (sticky_q | rsp_flags_q);
        end else if (sticky_clr) begin
            sticky_q <= 4'h0;
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp8_alu_arbiter.sv
// ============================================================================
// Module      : tb_fp8_alu_arbiter
// Description : Directed self-checking bench for fp8_alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp8_alu_arbiter;

    localparam logic [2:0] C_ADD = 3'b000;
    localparam logic [2:0] C_MUL = 3'b010;
    localparam logic [2:0] C_DIV = 3'b011;
    localparam logic [2:0] C_AND = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_flags;
    logic        busy;
`ifdef FP8_ARB_STICKY_FLAGS_EN
    logic        sticky_clr;
    logic [3:0]  sticky_flags;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp8_alu_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .busy         (busy)
`ifdef FP8_ARB_STICKY_FLAGS_EN
        ,
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] idx, input logic [7:0] a,
                             input logic [7:0] b, input logic [2:0] op);
        req_a[8*idx +: 8]  = a;
        req_b[8*idx +: 8]  = b;
        req_op[3*idx +: 3] = op;
        req_valid[idx]     = 1'b1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        #1;
        n_tests++;
        if (req_ready !== 4'h0) begin
            n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        n_tests++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL reset_valid_busy: got %b expected 00", {rsp_valid, busy});
        end
        n_tests++;
        if ({rsp_id, rsp_result, rsp_flags} !== 14'h0) begin
            n_fail++; $display("FAIL reset_rsp_fields: got id=%h res=%h flg=%h expected 0/00/0",
                               rsp_id, rsp_result, rsp_flags);
        end
`ifdef FP8_ARB_STICKY_FLAGS_EN
        n_tests++;
        if (sticky_flags !== 4'h0) begin
            n_fail++; $display("FAIL reset_sticky: got %h expected 0", sticky_flags);
        end
`endif
        req_valid = 4'h0;
        rst_n     = 1'b1;
        tick();
    endtask

    task automatic test_single();
        drive_req(2'd2, 8'h30, 8'h30, C_ADD);
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_ready: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = 4'h0;
        n_tests++;
        if ({busy, rsp_valid, req_ready} !== 6'b10_0000) begin
            n_fail++; $display("FAIL single_exec: got busy=%b vld=%b rdy=%b expected 1 0 0000",
                               busy, rsp_valid, req_ready);
        end
        tick();
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 2'd2, 8'h40, 4'h0}) begin
            n_fail++; $display("FAIL single_rsp: got vld=%b id=%0d res=%h flg=%h expected 1 2 40 0",
                               rsp_valid, rsp_id, rsp_result, rsp_flags);
        end
        tick();
        n_tests++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL single_done: got %b expected 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        logic [1:0] exp_id;
        do_reset();
        for (int i = 0; i < 4; i++) drive_req(2'(i), 8'h30, 8'h30, C_ADD);
        for (int k = 0; k < 5; k++) begin
            exp_id  = 2'(k % 4);
            exp_rdy = 4'b0001 << exp_id;
            #1;
            n_tests++;
            if (req_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_rdy);
            end
            tick();
            tick();
            n_tests++;
            if ({rsp_valid, rsp_id} !== {1'b1, exp_id}) begin
                n_fail++; $display("FAIL rr_id[%0d]: got vld=%b id=%0d expected 1 %0d",
                                   k, rsp_valid, rsp_id, exp_id);
            end
            tick();
        end
        req_valid = 4'h0;
    endtask

    task automatic test_ops();
        drive_req(2'd1, 8'h40, 8'h40, C_MUL);
        drive_req(2'd3, 8'hAA, 8'hCC, C_AND);
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL ops_ready_mul: got %b expected 0010", req_ready);
        end
        tick();
        req_valid[1] = 1'b0;
        tick();
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 2'd1, 8'h50, 4'h0}) begin
            n_fail++; $display("FAIL ops_mul: got vld=%b id=%0d res=%h flg=%h expected 1 1 50 0",
                               rsp_valid, rsp_id, rsp_result, rsp_flags);
        end
        tick();
        n_tests++;
        if (req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL ops_ready_and: got %b expected 1000", req_ready);
        end
        tick();
        req_valid[3] = 1'b0;
        tick();
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 2'd3, 8'h88, 4'h0}) begin
            n_fail++; $display("FAIL ops_and: got vld=%b id=%0d res=%h flg=%h expected 1 3 88 0",
                               rsp_valid, rsp_id, rsp_result, rsp_flags);
        end
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        drive_req(2'd0, 8'h30, 8'h40, C_ADD);   // 1.0 + 2.0 = 3.0 -> 0x48
        tick();
        req_valid = 4'b1110;
        n_tests++;
        if (req_ready !== 4'h0) begin
            n_fail++; $display("FAIL bp_exec_ready: got %b expected 0000", req_ready);
        end
        tick();
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if ({rsp_valid, busy, req_ready, rsp_id, rsp_result} !== {2'b11, 4'h0, 2'd0, 8'h48}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got vld=%b busy=%b rdy=%b id=%0d res=%h expected 1 1 0000 0 48",
                                   c, rsp_valid, busy, req_ready, rsp_id, rsp_result);
            end
            tick();
        end
        rsp_ready = 1'b1;
        n_tests++;
        if ({rsp_valid, rsp_result} !== {1'b1, 8'h48}) begin
            n_fail++; $display("FAIL bp_sixth: got vld=%b res=%h expected 1 48", rsp_valid, rsp_result);
        end
        tick();
        n_tests++;
        if ({busy, rsp_valid, req_ready} !== {2'b00, 4'b0010}) begin
            n_fail++; $display("FAIL bp_release: got busy=%b vld=%b rdy=%b expected 0 0 0010",
                               busy, rsp_valid, req_ready);
        end
        req_valid = 4'h0;
    endtask

    task automatic test_div_zero();
        drive_req(2'd2, 8'h30, 8'h00, C_DIV);
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL div_ready: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = 4'h0;
        tick();
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_flags[3]} !== {1'b1, 2'd2, 1'b1}) begin
            n_fail++; $display("FAIL div_invalid: got vld=%b id=%0d inv=%b expected 1 2 1",
                               rsp_valid, rsp_id, rsp_flags[3]);
        end
        tick();
`ifdef FP8_ARB_STICKY_FLAGS_EN
        n_tests++;
        if (sticky_flags[3] !== 1'b1) begin
            n_fail++; $display("FAIL sticky_set: got %b expected 1", sticky_flags[3]);
        end
`endif
        drive_req(2'd2, 8'h30, 8'h30, C_ADD);
        tick();
        req_valid = 4'h0;
        tick();
        n_tests++;
        if ({rsp_result, rsp_flags} !== {8'h40, 4'h0}) begin
            n_fail++; $display("FAIL div_clean_add: got res=%h flg=%h expected 40 0", rsp_result, rsp_flags);
        end
        tick();
`ifdef FP8_ARB_STICKY_FLAGS_EN
        n_tests++;
        if (sticky_flags !== 4'b1000) begin
            n_fail++; $display("FAIL sticky_keep: got %b expected 1000", sticky_flags);
        end
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        n_tests++;
        if (sticky_flags !== 4'h0) begin
            n_fail++; $display("FAIL sticky_clr: got %b expected 0000", sticky_flags);
        end
`endif
    endtask

    task automatic test_reset_mid_op();
        drive_req(2'd3, 8'h30, 8'h30, C_ADD);
        #1;
        n_tests++;
        if (req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL rmid_ready: got %b expected 1000", req_ready);
        end
        tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rmid_busy: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) drive_req(2'(i), 8'h40, 8'h30, C_ADD);
        #1;
        n_tests++;
        if ({busy, rsp_valid, req_ready, rsp_id, rsp_result, rsp_flags} !== 20'h0) begin
            n_fail++; $display("FAIL rmid_async: got busy=%b vld=%b rdy=%b id=%0d res=%h flg=%h expected all 0",
                               busy, rsp_valid, req_ready, rsp_id, rsp_result, rsp_flags);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rmid_first: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = 4'h0;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rmid_no_rsp: got %b expected 0", rsp_valid);
        end
        tick();
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd0, 8'h48}) begin
            n_fail++; $display("FAIL rmid_next: got vld=%b id=%0d res=%h expected 1 0 48",
                               rsp_valid, rsp_id, rsp_result);
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'h0;
        req_a     = 32'h0;
        req_b     = 32'h0;
        req_op    = 12'h0;
        rsp_ready = 1'b1;
`ifdef FP8_ARB_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_ops();
        test_backpressure();
        test_div_zero();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
